serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that drives the team's 1-bit full-adder cell and consumes its outputs. It loads two WIDTH-bit operands and a carry-in, then presents one bit pair per clock to the cell, LSB first. It holds the running carry in a flop and shifts the returned sum bits into a result register. The top-level wrapper wires fa_a/fa_b/fa_cin to the cell's A/B/Cin and the cell's sum/Cout back to fa_sum/fa_cout.

---
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_top.sv | 46 ++++
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/full_adder.sv
// 1-bit full-adder cell driven bit-serially by the adder controller.
// Ports: a, b, cin in; sum, cout out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_top.sv
// Serial adder unit: controller plus its 1-bit full-adder cell.
// Ports: start/a_in/b_in/cin_in in; busy/done/sum_out/cout_out out.
module serial_adder_top #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  serial_adder_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds a 1-bit FA cell LSB first, collects sum.
// Ports: start/a_in/b_in/cin_in in, fa_* cell link, busy/done/sum_out/cout_out.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             cout_out_q, cout_out_d;
  logic [WIDTH-1:0] sum_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_out_q  <= sum_out_d;
      cout_out_q <= cout_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_out_d  = sum_out_q;
    cout_out_d = cout_out_q;
    // sum bits enter at the MSB so the LSB-first stream lands in order
    sum_next          = sum_sh_q >> 1;
    sum_next[WIDTH-1] = fa_sum;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_next;
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_out_d  = sum_next;
          cout_out_d = fa_cout;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fa_a     = (state_q == RUN) & a_sh_q[0];
  assign fa_b     = (state_q == RUN) & b_sh_q[0];
  assign fa_cin   = (state_q == RUN) & carry_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_out_q;
  assign cout_out = cout_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the bit-serial adder controller.
// Instances at WIDTH 8 (controller + cell), 1 and 16 (wrapper).
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic       busy8, done8, cout8;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a_in     (a8),
    .b_in     (b8),
    .cin_in   (cin8),
    .fa_a     (fa_a8),
    .fa_b     (fa_b8),
    .fa_cin   (fa_cin8),
    .fa_sum   (fa_sum8),
    .fa_cout  (fa_cout8),
    .busy     (busy8),
    .done     (done8),
    .sum_out  (sum8),
    .cout_out (cout8)
  );

  full_adder u_fa8 (
    .a    (fa_a8),
    .b    (fa_b8),
    .cin  (fa_cin8),
    .sum  (fa_sum8),
    .cout (fa_cout8)
  );

  logic [0:0] a1, b1, sum1;
  logic       start1, cin1, busy1, done1, cout1;

  serial_adder_top #(.WIDTH(1)) u_w1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .a_in     (a1),
    .b_in     (b1),
    .cin_in   (cin1),
    .busy     (busy1),
    .done     (done1),
    .sum_out  (sum1),
    .cout_out (cout1)
  );

  logic [15:0] a16, b16, sum16;
  logic        start16, cin16, busy16, done16, cout16;

  serial_adder_top #(.WIDTH(16)) u_w16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .a_in     (a16),
    .b_in     (b16),
    .cin_in   (cin16),
    .busy     (busy16),
    .done     (done16),
    .sum_out  (sum16),
    .cout_out (cout16)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] last8 = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input bit bits);
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    check("w8_hold", 64'({cout8, sum8}), 64'(last8));
    for (int k = 0; k < 8; k++) begin
      check("w8_busy_run", 64'(busy8), 64'd1);
      check("w8_done_run", 64'(done8), 64'd0);
      if (bits) begin
        check("w8_fa_a", 64'(fa_a8), 64'(a[k]));
        check("w8_fa_b", 64'(fa_b8), 64'(b[k]));
      end
      @(negedge clk);
    end
    check("w8_done", 64'(done8), 64'd1);
    check("w8_busy_done", 64'(busy8), 64'd0);
    check("w8_result", 64'({cout8, sum8}), 64'(exp));
    last8 = exp;
    @(negedge clk);
    check("w8_done_clr", 64'(done8), 64'd0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {1'b0, c};
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", 64'(busy1), 64'd1);
    check("w1_done_run", 64'(done1), 64'd0);
    @(negedge clk);
    check("w1_done", 64'(done1), 64'd1);
    check("w1_result", 64'({cout1, sum1}), 64'(exp));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    logic [16:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    @(negedge clk);
    start16 = 1'b0;
    repeat (15) @(negedge clk);
    check("w16_pre_done", 64'({busy16, done16}), 64'b10);
    @(negedge clk);
    check("w16_done", 64'({busy16, done16}), 64'b01);
    check("w16_result", 64'({cout16, sum16}), 64'(exp));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    start16 = 0; a16 = '0; b16 = '0; cin16 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'({cout8, sum8}), 64'd0);
    check("rst_fa", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
    rst_n = 1'b1;

    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h5A, 8'h33, 1'b1, 1'b1);
    check("dir_5a33", 64'(last8), 64'h08E);

    // start held high: new add accepted on each done cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      check("hold_done", 64'(done8), 64'(i % 9 == 8));
      check("hold_busy", 64'(busy8), 64'(i % 9 != 8));
      if (i % 9 == 8)
        check("hold_sum", 64'({cout8, sum8}), 64'h002);
    end
    start8 = 1'b0;
    @(negedge clk);
    check("hold_stop", 64'(busy8), 64'd0);

    // reset mid-operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_sum", 64'({cout8, sum8}), 64'd0);
    check("abort_fa", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last8 = '0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done8;
    end
    check("abort_nodone", 64'(seen), 64'd0);
    op8(8'h10, 8'h20, 1'b0, 1'b1);
    check("after_abort", 64'(last8), 64'h030);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t = 3'(v);
      op1(t[2], t[1], t[0]);
    end

    for (int n = 0; n < 500; n++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int n = 0; n < 500; n++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
